// File: rtl/sw_feeder.sv
// sw_feeder
//   Drives the head of a Smith-Waterman systolic PE chain. Accepts one job (a query
//   S vector plus a database T length). It then streams that many T symbols into PE0,
//   tagging the first symbol with changeS and every live symbol with init. When the
//   job ends it flushes the chain with N_PE init=0 bubbles and pulses done.
//
// Parameters
//   N_PE   number of PEs; the S vector carries one 2-bit symbol per PE
//   LEN_W  width of the T length field / counter
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cfg_valid/ready     job descriptor handshake (ready only in IDLE, low during rst)
//   cfg_s_vec           query symbols, bits[2k+1:2k] belong to PE k
//   cfg_t_len           number of T symbols in the job
//   t_valid/ready/data  T symbol stream (ready only while streaming)
//   pe_S                registered S_in bus to all PEs, held from accept to next accept
//   pe_changeS          registered changeS_in for PE0 (first symbol of a job only)
//   pe_T, pe_init       registered T_in / init_in for PE0
//   busy                engine not idle
//   done                one-cycle pulse at job end
//   err                 sticky underrun flag, cleared on the next job accept or rst
module sw_feeder #(
    parameter int N_PE  = 16,
    parameter int LEN_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2*N_PE-1:0]   cfg_s_vec,
    input  logic [LEN_W-1:0]    cfg_t_len,
    input  logic                t_valid,
    output logic                t_ready,
    input  logic [1:0]          t_data,
    output logic [2*N_PE-1:0]   pe_S,
    output logic                pe_changeS,
    output logic [1:0]          pe_T,
    output logic                pe_init,
    output logic                busy,
    output logic                done,
    output logic                err
);

    // Sized to hold N_PE-1 even when N_PE is a power of two or 1.
    localparam int DRAIN_W = $clog2(N_PE + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(N_PE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [2*N_PE-1:0]    s_q;
    logic [LEN_W-1:0]     len_cnt_q;
    logic [DRAIN_W-1:0]   drain_cnt_q;
    logic                 first_q;
    logic [1:0]           t_q;
    logic                 init_q;
    logic                 change_s_q;
    logic                 done_q;
    logic                 err_q;

    // Handshake readies are decoded straight from state so a symbol is taken in the
    // same cycle it is offered; rst masks cfg_ready so nothing is accepted mid-reset.
    assign cfg_ready  = (state_q == S_IDLE) && !rst;
    assign t_ready    = (state_q == S_STREAM);
    assign busy       = (state_q != S_IDLE);

    assign pe_S       = s_q;
    assign pe_changeS = change_s_q;
    assign pe_T       = t_q;
    assign pe_init    = init_q;
    assign done       = done_q;
    assign err        = err_q;

    // NOTE: every register here is updated with <= so all of them see the same
    // pre-edge values; a blocking update would leak new state into later statements.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            s_q         <= '0;
            len_cnt_q   <= '0;
            drain_cnt_q <= '0;
            first_q     <= 1'b0;
            t_q         <= 2'd0;
            init_q      <= 1'b0;
            change_s_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cfg_valid) begin
                        s_q       <= cfg_s_vec;
                        len_cnt_q <= cfg_t_len;
                        first_q   <= 1'b1;
                        err_q     <= 1'b0;
                        // An empty job goes straight to DONE and never raises init.
                        state_q   <= (cfg_t_len == '0) ? S_DONE : S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (t_valid) begin
                        t_q        <= t_data;
                        init_q     <= 1'b1;
                        change_s_q <= first_q;
                        first_q    <= 1'b0;
                        len_cnt_q  <= len_cnt_q - LEN_W'(1);
                        if (len_cnt_q == LEN_W'(1)) begin
                            state_q     <= S_DRAIN;
                            drain_cnt_q <= DRAIN_LAST;
                        end
                    end else begin
                        // The chain cannot stall: a missing symbol aborts the job and
                        // the remaining symbols are left unconsumed.
                        err_q       <= 1'b1;
                        t_q         <= 2'd0;
                        init_q      <= 1'b0;
                        change_s_q  <= 1'b0;
                        state_q     <= S_DRAIN;
                        drain_cnt_q <= DRAIN_LAST;
                    end
                end

                S_DRAIN: begin
                    t_q        <= 2'd0;
                    init_q     <= 1'b0;
                    change_s_q <= 1'b0;
                    if (drain_cnt_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
                    end
                end

                S_DONE: begin
                    t_q        <= 2'd0;
                    init_q     <= 1'b0;
                    change_s_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_feeder.sv
// tb_sw_feeder
//   Directed bench for sw_feeder with N_PE=4. A timeline model schedules the expected
//   PE0 outputs and done pulse by cycle number from job events, and a compare process
//   checks every output on every cycle; literal checks pin key latencies and values.
module tb_sw_feeder;

    localparam int N_PE  = 4;
    localparam int LEN_W = 10;
    localparam int SW    = 2 * N_PE;
    localparam int MAXC  = 1024;

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [SW-1:0]     cfg_s_vec;
    logic [LEN_W-1:0]  cfg_t_len;
    logic              t_valid;
    logic              t_ready;
    logic [1:0]        t_data;
    logic [SW-1:0]     pe_S;
    logic              pe_changeS;
    logic [1:0]        pe_T;
    logic              pe_init;
    logic              busy;
    logic              done;
    logic              err;

    sw_feeder #(.N_PE(N_PE), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_s_vec  (cfg_s_vec),
        .cfg_t_len  (cfg_t_len),
        .t_valid    (t_valid),
        .t_ready    (t_ready),
        .t_data     (t_data),
        .pe_S       (pe_S),
        .pe_changeS (pe_changeS),
        .pe_T       (pe_T),
        .pe_init    (pe_init),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;   // index of the current cycle (incremented at each rising edge)

    // Timeline model: job-level facts plus per-cycle expected PE0 outputs.
    bit            m_stream  = 1'b0;  // a job is consuming T symbols this cycle
    bit            m_first   = 1'b0;
    bit            m_err     = 1'b0;
    int            m_rem     = 0;
    int            m_free_at = 0;     // first cycle the engine is idle again
    logic [SW-1:0] m_S       = '0;
    bit [1:0]      x_T    [MAXC];
    bit            x_init [MAXC];
    bit            x_cs   [MAXC];
    bit            x_done [MAXC];
    bit            cmp_idle;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A job ending at cycle c drains N_PE cycles, spends one in DONE, and the
    // registered done pulse appears the cycle after that.
    task automatic end_job(input int c);
        m_stream       = 1'b0;
        x_done[c+N_PE+2] = 1'b1;
        m_free_at      = c + N_PE + 2;
    endtask

    // Model: consume the inputs of the cycle that just ended.
    initial begin
        forever begin
            @(posedge clk);
            if (cyc >= MAXC - N_PE - 8) begin
                $display("FAIL model_range: cycle %0d beyond table", cyc);
                $fatal(1, "model table exhausted");
            end
            if (rst) begin
                m_stream  = 1'b0;
                m_free_at = cyc + 1;
                m_err     = 1'b0;
                m_S       = '0;
                for (int i = cyc + 1; i <= cyc + N_PE + 3; i++) begin
                    x_T[i]    = 2'd0;
                    x_init[i] = 1'b0;
                    x_cs[i]   = 1'b0;
                    x_done[i] = 1'b0;
                end
            end else if (m_stream) begin
                if (t_valid) begin
                    x_T[cyc+1]    = t_data;
                    x_init[cyc+1] = 1'b1;
                    x_cs[cyc+1]   = m_first;
                    m_first       = 1'b0;
                    m_rem--;
                    if (m_rem == 0) end_job(cyc);
                end else begin
                    m_err = 1'b1;
                    end_job(cyc);
                end
            end else if (cyc >= m_free_at && cfg_valid) begin
                m_S   = cfg_s_vec;
                m_err = 1'b0;
                if (cfg_t_len == '0) begin
                    x_done[cyc+2] = 1'b1;
                    m_free_at     = cyc + 2;
                end else begin
                    m_stream = 1'b1;
                    m_first  = 1'b1;
                    m_rem    = int'(cfg_t_len);
                end
            end
            cyc++;
        end
    end

    // Compare process: every output, every cycle after the first edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                cmp_idle = !m_stream && (cyc >= m_free_at);
                check("cfg_ready",  cfg_ready,  cmp_idle && !rst);
                check("t_ready",    t_ready,    m_stream);
                check("busy",       busy,       !cmp_idle);
                check("pe_S",       pe_S,       m_S);
                check("err",        err,        m_err);
                check("pe_T",       pe_T,       x_T[cyc]);
                check("pe_init",    pe_init,    x_init[cyc]);
                check("pe_changeS", pe_changeS, x_cs[cyc]);
                check("done",       done,       x_done[cyc]);
            end
        end
    end

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            @(negedge clk);
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int a;
    int d;
    int d2;

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_s_vec = '0;
        cfg_t_len = '0;
        t_valid   = 1'b0;
        t_data    = 2'd0;

        // Reset state.
        repeat (2) step();
        @(negedge clk);
        check("rst_pe_S",      pe_S,      8'h00);
        check("rst_pe_init",   pe_init,   1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_err",       err,       1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b0);

        // t_valid while idle is ignored.
        step(); rst = 1'b0; t_valid = 1'b1; t_data = 2'd3;
        step();
        step();
        @(negedge clk);
        check("idle_t_ready", t_ready, 1'b0);
        check("idle_pe_T",    pe_T,    2'd0);

        // T1: three symbols back-to-back.
        step(); t_valid = 1'b0; a = cyc;
        cfg_valid = 1'b1; cfg_s_vec = 8'hE4; cfg_t_len = 10'd3;
        step(); cfg_valid = 1'b0; t_valid = 1'b1; t_data = 2'd2;
        step(); t_data = 2'd1;
        @(negedge clk);
        check("t1_T0",  pe_T,       2'd2);
        check("t1_cs0", pe_changeS, 1'b1);
        check("t1_in0", pe_init,    1'b1);
        step(); t_data = 2'd3;
        @(negedge clk);
        check("t1_T1",  pe_T,       2'd1);
        check("t1_cs1", pe_changeS, 1'b0);
        step(); t_valid = 1'b0;
        @(negedge clk);
        check("t1_T2",  pe_T,    2'd3);
        check("t1_in2", pe_init, 1'b1);
        wait_done(40, d);
        check("t1_done_lat", d - a, 9);
        check("t1_S",        pe_S,  8'hE4);

        // T2: empty job.
        step(); a = cyc;
        cfg_valid = 1'b1; cfg_s_vec = 8'h1B; cfg_t_len = 10'd0;
        step(); cfg_valid = 1'b0; t_valid = 1'b1; t_data = 2'd2;
        wait_done(10, d);
        check("t2_done_lat", d - a, 2);
        check("t2_S",        pe_S,  8'h1B);

        // T3: underrun after two of five symbols.
        step(); t_valid = 1'b0; a = cyc;
        cfg_valid = 1'b1; cfg_s_vec = 8'h5A; cfg_t_len = 10'd5;
        step(); cfg_valid = 1'b0; t_valid = 1'b1; t_data = 2'd0;
        step(); t_data = 2'd3;
        step(); t_valid = 1'b0;
        step(); t_valid = 1'b1; t_data = 2'd1;
        @(negedge clk);
        check("t3_err",     err,     1'b1);
        check("t3_init",    pe_init, 1'b0);
        check("t3_t_ready", t_ready, 1'b0);
        wait_done(30, d);
        check("t3_done_lat", d - a, 9);
        check("t3_err_done", err,   1'b1);
        step(); t_valid = 1'b0;
        @(negedge clk);
        check("t3_err_idle", err, 1'b1);

        // T4: reset in the middle of a stream.
        step(); a = cyc;
        cfg_valid = 1'b1; cfg_s_vec = 8'hC3; cfg_t_len = 10'd4;
        step(); cfg_valid = 1'b0; t_valid = 1'b1; t_data = 2'd1;
        step(); t_data = 2'd2;
        step(); rst = 1'b1; t_data = 2'd3;
        step(); rst = 1'b0; t_valid = 1'b0;
        @(negedge clk);
        check("t4_S",     pe_S,       8'h00);
        check("t4_T",     pe_T,       2'd0);
        check("t4_init",  pe_init,    1'b0);
        check("t4_cs",    pe_changeS, 1'b0);
        check("t4_ready", cfg_ready,  1'b1);
        check("t4_busy",  busy,       1'b0);

        // T5: cfg_valid held across two jobs; first one underruns.
        step(); a = cyc;
        cfg_valid = 1'b1; cfg_s_vec = 8'h96; cfg_t_len = 10'd3;
        step(); cfg_s_vec = 8'h3C; cfg_t_len = 10'd2; t_valid = 1'b1; t_data = 2'd2;
        step(); t_valid = 1'b0;
        wait_done(30, d);
        check("t5_done_lat", d - a, 8);
        check("t5_S_A",      pe_S,  8'h96);
        check("t5_err_A",    err,   1'b1);
        step(); cfg_valid = 1'b0; t_valid = 1'b1; t_data = 2'd3;
        @(negedge clk);
        check("t5_S_B",   pe_S,    8'h3C);
        check("t5_err_B", err,     1'b0);
        check("t5_busy",  busy,    1'b1);
        step(); t_data = 2'd0;
        @(negedge clk);
        check("t5_T0",  pe_T,       2'd3);
        check("t5_cs0", pe_changeS, 1'b1);
        step(); t_valid = 1'b0;
        @(negedge clk);
        check("t5_T1",  pe_T,       2'd0);
        check("t5_in1", pe_init,    1'b1);
        check("t5_cs1", pe_changeS, 1'b0);
        wait_done(30, d2);
        check("t5_done_lat_B", d2 - d, 8);

        // Single-symbol job.
        step(); a = cyc;
        cfg_valid = 1'b1; cfg_s_vec = 8'hFF; cfg_t_len = 10'd1;
        step(); cfg_valid = 1'b0; t_valid = 1'b1; t_data = 2'd1;
        step(); t_valid = 1'b0;
        @(negedge clk);
        check("t7_T",  pe_T,       2'd1);
        check("t7_cs", pe_changeS, 1'b1);
        wait_done(30, d);
        check("t7_done_lat", d - a, 7);

        repeat (3) step();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
